// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and datapath width.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    typedef enum logic [2:0] {
        AND  = 3'b000,
        OR   = 3'b001,
        ADD  = 3'b010,
        ADDX = 3'b011,
        ANDN = 3'b100,
        ORN  = 3'b101,
        SUB  = 3'b110,
        SLT  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between NREQ requesters and the shared-ALU arbiter.
interface alu_share_arb_if
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) ();

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0][ALU_W-1:0] req_a;
    logic [NREQ-1:0][ALU_W-1:0] req_b;
    logic [NREQ-1:0][2:0]       req_ctrl;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ALU_W-1:0]           rsp_y;
    logic                       rsp_zero;
    logic [IDW-1:0]             rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past the last winner.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters; results return through a
// one-entry response register tagged with the issuing requester's index.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_share_arb_if.slave   bus,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [ALU_W-1:0] alu_y,
    input  logic             alu_zero
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_id;
    logic             can_issue;
    logic             fire;

    logic             rsp_valid_q, rsp_valid_d;
    logic [ALU_W-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [IDW-1:0]   last_q, last_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req    (bus.req_valid),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        can_issue     = !rsp_valid_q || bus.rsp_ready;
        // Nothing is accepted while reset is held, so no request is lost.
        bus.req_ready = (rst_n && can_issue) ? gnt : '0;
        fire          = |(bus.req_valid & bus.req_ready);

        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (|gnt) begin
            alu_a    = bus.req_a[gnt_id];
            alu_b    = bus.req_b[gnt_id];
            alu_ctrl = bus.req_ctrl[gnt_id];
        end

        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_id_d    = rsp_id_q;
        last_d      = last_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_y_d     = alu_y;
            rsp_zero_d  = alu_zero;
            rsp_id_d    = gnt_id;
            last_d      = gnt_id;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= '0;
            last_q      <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_id_q    <= rsp_id_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        bus.rsp_valid = rsp_valid_q;
        bus.rsp_y     = rsp_y_q;
        bus.rsp_zero  = rsp_zero_q;
        bus.rsp_id    = rsp_id_q;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares the single 32-bit combinational `alu` between NREQ independent requesters, such as a branch-compare unit and the main execute stage.
- Each requester presents operands and a 3-bit ALUControl code under a valid/ready handshake.
- The block muxes the granted request onto the ALU and captures y/zero in a one-entry response register.
- The response is returned tagged with the requester ID under its own valid/ready handshake.
- The block sits between the requesters and the `alu` instance; the `alu` stays unmodified.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-ID width (derived; do not override).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ×32  operand A per requester (packed array).
- req_b  in  NREQ×32  operand B per requester.
- req_ctrl  in  NREQ×3  ALUControl code per requester.
- alu_a  out  32  to alu A.
- alu_b  out  32  to alu B.
- alu_ctrl  out  3  to alu ALUControl.
- alu_y  in  32  from alu y.
- alu_zero  in  1  from alu zero.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_y  out  32  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_id  out  IDW  index of requester that issued the response.

## Operation
- `can_issue = !rsp_valid || rsp_ready`. The response register is empty, or it drains this cycle.
- Grant is combinational round-robin over `req_valid`:
  - Search starts at `last_grant+1` (mod NREQ).
  - The first valid requester found wins.
  - `grant` is zero when no request is valid.
- `req_ready[i] = grant[i] && can_issue`.
- A fire on requester i means `req_valid[i] && req_ready[i]`. At most one fire occurs per cycle.
- ALU inputs:
  - `alu_a/alu_b/alu_ctrl` are driven from the granted requester.
  - When no grant, they are driven to all-zero. This gives deterministic ALU inputs and `y=0`.
- On fire:
  - `rsp_y<=alu_y`, `rsp_zero<=alu_zero`, `rsp_id<=i`, `rsp_valid<=1`.
  - `last_grant<=i`.
- On `rsp_valid && rsp_ready` with no fire: `rsp_valid<=0`.
- Drain and fire in the same cycle: the new response replaces the old one. `rsp_valid` stays 1, giving back-to-back throughput of 1 op/cycle.
- `last_grant` updates only on fire. Stalled grants do not rotate the pointer.
- A requester must hold `req_*` stable while `req_valid=1 && !req_ready`. The block does not check this; the bench asserts it.
- `rsp_*` is held stable while `rsp_valid && !rsp_ready`.
- Arbitration is fair: with all requesters continuously valid and `rsp_ready=1`, each requester is served exactly once per NREQ cycles.
- The block does not interpret ALUControl. Code 011 and all other codes pass through unchanged.

## Timing
- Reset values, applied at the first rising edge with `rst_n=0`:
  - `rsp_valid=0`, `rsp_y=0`, `rsp_zero=0`, `rsp_id=0`.
  - `last_grant=NREQ-1`, so requester 0 wins the first contention.
- Latency: a request firing in cycle N produces `rsp_valid=1` with its result in cycle N+1.
- Reset mid-operation: a pending response is discarded, with no drain. `req_ready` is 0 for every cycle `rst_n=0`.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. `rsp_*` is a registered output only.
- The combinational path runs req mux → alu → response register in one cycle. The target is one ALU delay plus a NREQ:1 mux.

## Structure
- Package `alu_pkg`:
  - `typedef enum logic [2:0] alu_op_e` with values AND=000, OR=001, ADD=010, ADDX=011, ANDN=100, ORN=101, SUB=110, SLT=111.
  - `localparam ALU_W=32`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: req[N], last[IDW].
  - Outputs: gnt one-hot, gnt_id.
  - Purely combinational, and reused later for register-file port sharing.
- The `alu` is instantiated outside this block. The top level wires `alu_*`.

## Test plan
- Reset, then req0 = {A=5, B=7, ctrl=010} with `rsp_ready=1`: next cycle `rsp_valid=1`, `rsp_y=12`, `rsp_zero=0`, `rsp_id=0`.
- req1 = {A=9, B=9, ctrl=110}: `rsp_y=0`, `rsp_zero=1`, `rsp_id=1`. Also req0 = {A=3, B=4, ctrl=111}: `rsp_y=1`.
- Both requesters continuously valid for 6 cycles, `rsp_ready=1`: `rsp_id` sequence is 0,1,0,1,0,1, one response per cycle, no bubbles.
- `rsp_ready=0` with one response pending and both requesters valid:
  - `req_ready=0` for both.
  - `rsp_*` is stable for 4 cycles.
  - After raising `rsp_ready`, the next grant goes to the requester not previously served.
- Pull `rst_n=0` for 1 cycle while `rsp_valid=1` and req0 is valid:
  - Next cycle `rsp_valid=0`.
  - Then with both requesters valid, the first grant is `rsp_id=0`.
- Only req1 valid for 3 consecutive ops: served every cycle, `rsp_id=1` each cycle, and the pointer does not starve req0 when it later asserts.
